// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: ALU select decode plus an iterative multiply/divide engine
// with HI/LO registers. The engine runs WIDTH shift-add / restoring-subtract
// steps, then applies the result sign. While it is busy, any further MD
// instruction is stalled.
module alu_ctrl_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        funct,
    input  logic [1:0]        aluop,
    input  logic              issue,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic [CTRL_W-1:0] aluctrl,
    output logic              md_busy,
    output logic              md_done,
    output logic              stall,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t             state_r, state_n;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   opnd_r;       // multiplicand (mult) or divisor (div) magnitude
    logic [2*WIDTH-1:0] p_r;          // {acc, multiplier} or {remainder, quotient}
    logic               is_div_r;
    logic               neg_q_r;      // operand signs differ on a signed op
    logic               neg_r_r;      // signed dividend is negative
    logic               dz_r;         // divisor was zero
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               md_busy_r, md_done_r;

    logic               is_muldiv_s, is_md_s, start_s, mthi_s, mtlo_s, signed_op_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] p_step_s, prod_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;
    logic [3:0]         alu_sel_s;

    assign is_muldiv_s = (aluop == 2'b10) && (funct[5:2] == 4'b0110);
    assign is_md_s     = (aluop == 2'b10) && ((funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100));
    assign start_s     = issue && is_muldiv_s && (state_r == IDLE);
    assign mthi_s      = issue && (aluop == 2'b10) && (funct == 6'b010001);
    assign mtlo_s      = issue && (aluop == 2'b10) && (funct == 6'b010011);
    assign signed_op_s = ~funct[0];
    assign mag_a_s     = (signed_op_s && op_a[WIDTH-1]) ? ((~op_a) + ONE_W) : op_a;
    assign mag_b_s     = (signed_op_s && op_b[WIDTH-1]) ? ((~op_b) + ONE_W) : op_b;

    assign aluctrl = CTRL_W'(alu_sel_s);
    assign md_busy = md_busy_r;
    assign md_done = md_done_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

    // ALU select decode, independent of the engine state
    always_comb begin
        alu_sel_s = 4'b0000;
        case (aluop)
            2'b00: alu_sel_s = 4'b0010;
            2'b01: alu_sel_s = 4'b0110;
            2'b11: alu_sel_s = 4'b0111;
            2'b10: begin
                case (funct)
                    6'b100000: alu_sel_s = 4'b0010;
                    6'b100010: alu_sel_s = 4'b0110;
                    6'b100100: alu_sel_s = 4'b0000;
                    6'b100101: alu_sel_s = 4'b0001;
                    6'b100110: alu_sel_s = 4'b1000;
                    6'b100111: alu_sel_s = 4'b1001;
                    6'b101010: alu_sel_s = 4'b0111;
                    6'b101011: alu_sel_s = 4'b1010;
                    default:   alu_sel_s = 4'b0000;
                endcase
            end
            default: alu_sel_s = 4'b0000;
        endcase
    end

    // Stall any MD instruction while the engine is occupied
    always_comb begin
        if (issue && is_md_s && md_busy_r) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // FSM next state
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_STEP) begin
                    state_n = FIX;
                end else begin
                    state_n = RUN;
                end
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM state register with busy/done flags registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            md_busy_r <= 1'b0;
            md_done_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            md_busy_r <= (state_n != IDLE);
            md_done_r <= (state_n == FIX);
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum_s   = {1'b0, p_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        div_shift_s = {p_r[2*WIDTH-1:WIDTH], p_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        p_step_s    = p_r;
        if (is_div_r) begin
            if (div_shift_s >= {1'b0, opnd_r}) begin
                p_step_s = {div_diff_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b1};
            end else begin
                p_step_s = {div_shift_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (p_r[0]) begin
                p_step_s = {mul_sum_s, p_r[WIDTH-1:1]};
            end else begin
                p_step_s = {1'b0, p_r[2*WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up; a zero divisor keeps the all-ones quotient unsigned
    always_comb begin
        prod_s   = neg_q_r ? ((~p_r) + ONE_2W) : p_r;
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (is_div_r) begin
            fix_hi_s = neg_r_r ? ((~p_r[2*WIDTH-1:WIDTH]) + ONE_W) : p_r[2*WIDTH-1:WIDTH];
            if (dz_r) begin
                fix_lo_s = ONES_W;
            end else begin
                fix_lo_s = neg_q_r ? ((~p_r[WIDTH-1:0]) + ONE_W) : p_r[WIDTH-1:0];
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Engine datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            opnd_r   <= ZERO_W;
            p_r      <= {ZERO_W, ZERO_W};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        is_div_r <= funct[1];
                        opnd_r   <= funct[1] ? mag_b_s : mag_a_s;
                        p_r      <= {ZERO_W, (funct[1] ? mag_a_s : mag_b_s)};
                        neg_q_r  <= signed_op_s && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_r_r  <= signed_op_s && op_a[WIDTH-1];
                        dz_r     <= (op_b == ZERO_W);
                    end else if (mthi_s) begin
                        hi_r <= op_a;
                    end else if (mtlo_s) begin
                        lo_r <= op_a;
                    end
                end
                RUN: begin
                    p_r   <= p_step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed self-checking bench for alu_ctrl_muldiv (WIDTH=32).
module tb_alu_ctrl_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        issue;
    logic [31:0] op_a, op_b;
    logic [3:0]  aluctrl;
    logic        md_busy, md_done, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    alu_ctrl_muldiv #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset), .funct(funct), .aluop(aluop), .issue(issue),
        .op_a(op_a), .op_b(op_b), .aluctrl(aluctrl), .md_busy(md_busy),
        .md_done(md_done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
        issue = 1'b1; aluop = op; funct = f; op_a = a; op_b = b;
    endtask

    task automatic idle_in();
        issue = 1'b0; aluop = 2'b00; funct = 6'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_in(); op_a = 32'd0; op_b = 32'd0;
        tick(); tick();
        checks++;
        if ({hi, lo} !== 64'd0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, md_busy, md_done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_aluctrl();
        logic [1:0] ops [12];
        logic [5:0] fs  [12];
        logic [3:0] exp [12];
        ops = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        fs  = '{6'd0, 6'd0, 6'd0, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b111111};
        exp = '{4'b0010, 4'b0110, 4'b0111, 4'b0010, 4'b0110, 4'b0000, 4'b0001,
                4'b1000, 4'b1001, 4'b0111, 4'b1010, 4'b0000};
        for (int i = 0; i < 12; i++) begin
            issue = 1'b0; aluop = ops[i]; funct = fs[i];
            #1;
            checks++;
            if (aluctrl !== exp[i]) begin
                errors++;
                $display("FAIL aluctrl[%0d] aluop=%b funct=%b: got %b expected %b", i, ops[i], fs[i], aluctrl, exp[i]);
            end
        end
        idle_in();
        tick();
    endtask

    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        bit seen;
        cyc = 0; seen = 1'b0;
        present(2'b10, f, a, b);
        while (!seen && cyc < 60) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                idle_in();
                checks++;
                if (md_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: got %b expected 1", name, md_busy);
                end
            end
            if (md_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != 33) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (done seen=%0d) expected 33", name, cyc, seen);
        end
        tick();
        checks++;
        if (hi !== exp_hi || lo !== exp_lo || md_busy !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
                     name, hi, lo, md_busy, md_done, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        present(2'b10, 6'b010001, 32'h0000_1234, 32'd0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL mthi stall: got %b expected 0", stall);
        end
        tick();
        present(2'b10, 6'b010011, 32'hCAFE_0001, 32'd0);
        checks++;
        if (hi !== 32'h0000_1234) begin
            errors++;
            $display("FAIL mthi: got %h expected 00001234", hi);
        end
        tick();
        idle_in();
        checks++;
        if (lo !== 32'hCAFE_0001 || hi !== 32'h0000_1234) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h expected hi=00001234 lo=cafe0001", hi, lo);
        end
    endtask

    // mult 2*3; mflo presented after the third edge; stall holds until the engine is idle
    task automatic test_stall_mflo();
        int k;
        present(2'b10, 6'b011000, 32'd2, 32'd3);
        tick(); idle_in(); k = 0;          // k counts edges after the accepting edge
        tick(); k++;
        tick(); k++;
        present(2'b10, 6'b010010, 32'h5555_5555, 32'd0);
        while (k < 33) begin
            #1;
            checks++;
            if (stall !== 1'b1 || md_done !== (k == 32)) begin
                errors++;
                $display("FAIL stall_mflo k=%0d: stall=%b done=%b expected stall=1 done=%0d", k, stall, md_done, (k == 32));
            end
            tick(); k++;
        end
        #1;
        checks++;
        if (stall !== 1'b0 || lo !== 32'd6 || hi !== 32'd0) begin
            errors++;
            $display("FAIL stall_mflo accept: stall=%b hi=%h lo=%h expected stall=0 hi=0 lo=6", stall, hi, lo);
        end
        tick();
        idle_in();
    endtask

    // Non-MD add during RUN proceeds; an mthi during RUN stalls and is dropped
    task automatic test_nonmd_during_run();
        present(2'b10, 6'b011001, 32'd10, 32'd10);
        tick(); idle_in();
        tick(); tick();
        present(2'b10, 6'b100000, 32'd1, 32'd2);
        #1;
        checks++;
        if (stall !== 1'b0 || aluctrl !== 4'b0010 || md_busy !== 1'b1) begin
            errors++;
            $display("FAIL add_during_run: stall=%b aluctrl=%b busy=%b expected 0 0010 1", stall, aluctrl, md_busy);
        end
        tick();
        present(2'b10, 6'b010001, 32'hDEAD_BEEF, 32'd0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL mthi_during_run stall: got %b expected 1", stall);
        end
        tick();
        idle_in();
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (hi !== 32'd0 || lo !== 32'd100) begin
            errors++;
            $display("FAIL multu 10*10: hi=%h lo=%h expected hi=0 lo=64", hi, lo);
        end
    endtask

    task automatic test_reset_mid_div();
        int dones;
        dones = 0;
        present(2'b10, 6'b011011, 32'd100, 32'd7);
        tick(); idle_in();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (md_done === 1'b1) dones++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h expected all zero", md_busy, md_done, hi, lo);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done === 1'b1 || md_busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_div aftermath: got %0d done/busy cycles expected 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_aluctrl();
        run_md("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("mult_neg",  6'b011000, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("div_neg",   6'b011010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_zero", 6'b011011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_md("divu_100_7", 6'b011011, 32'd100,      32'd7,         32'd2,         32'd14);
        test_mthi_mtlo();
        test_stall_mflo();
        test_nonmd_during_run();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
